// File: rtl/iq_issue_sched_if.sv
// Issue-scheduler bus: queue state in, issue slots and per-entry issued bits out.
// The scheduler is the slave; the instruction queue / issue logic side is the master.
interface iq_issue_sched_if #(
  parameter int IQ_DEPTH = 8,
  parameter int POS_W    = 3
);
  logic [IQ_DEPTH-1:0] validbit;
  logic [IQ_DEPTH-1:0] is_mem;
  logic [IQ_DEPTH-1:0] nodep;
  logic [POS_W-1:0]    head;
  logic [1:0]          alu_ready;
  logic                mem_ready;
  logic [IQ_DEPTH-1:0] replay;
  logic                flush;

  logic [1:0]          alu_valid;
  logic [POS_W-1:0]    alu_iqpos0;
  logic [POS_W-1:0]    alu_iqpos1;
  logic                mem_valid;
  logic [POS_W-1:0]    mem_iqpos;
  logic [IQ_DEPTH-1:0] issued;

  modport master (
    output validbit, is_mem, nodep, head, alu_ready, mem_ready, replay, flush,
    input  alu_valid, alu_iqpos0, alu_iqpos1, mem_valid, mem_iqpos, issued
  );

  modport slave (
    input  validbit, is_mem, nodep, head, alu_ready, mem_ready, replay, flush,
    output alu_valid, alu_iqpos0, alu_iqpos1, mem_valid, mem_iqpos, issued
  );
endinterface

// File: rtl/iq_issue_sched.sv
// Oldest-first issue scheduler: two ALU slots plus one in-order memory slot,
// with registered slot outputs and per-entry issued bits.
module iq_issue_sched #(
  parameter int IQ_DEPTH = 8,
  parameter int POS_W    = 3
) (
  input logic            clk,
  input logic            nrst,
  iq_issue_sched_if.slave bus
);

  logic [IQ_DEPTH-1:0] issued_reg;
  logic [IQ_DEPTH-1:0] issued_next;
  logic [1:0]          alu_valid_reg;
  logic [POS_W-1:0]    alu_iqpos0_reg;
  logic [POS_W-1:0]    alu_iqpos1_reg;
  logic                mem_valid_reg;
  logic [POS_W-1:0]    mem_iqpos_reg;

  logic [IQ_DEPTH-1:0] alu_cand;
  logic [IQ_DEPTH-1:0] mem_pend;
  logic [IQ_DEPTH-1:0] alu_rot;
  logic [IQ_DEPTH-1:0] mem_rot;

  logic                a_found, b_found, m_found;
  logic [POS_W-1:0]    a_age, b_age, m_age;
  logic [POS_W-1:0]    a_pos, b_pos, m_pos;

  logic                s0_fire, s1_fire, mem_fire;
  logic [POS_W-1:0]    s0_pos, s1_pos;
  logic [IQ_DEPTH-1:0] set_vec;
  logic [IQ_DEPTH-1:0] clr_vec;

  assign alu_cand = bus.validbit & bus.nodep & ~issued_reg & ~bus.is_mem;
  // Memory head-of-line ignores nodep so a younger ready op cannot bypass it.
  assign mem_pend = bus.validbit & bus.is_mem & ~issued_reg;

  // Rotate so that bit j of the rotated vector is the entry of age j.
  generate
    for (genvar gi = 0; gi < IQ_DEPTH; gi++) begin : g_rot
      logic [POS_W-1:0] pos;
      assign pos         = bus.head + POS_W'(gi);
      assign alu_rot[gi] = alu_cand[pos];
      assign mem_rot[gi] = mem_pend[pos];
    end
  endgenerate

  always_comb begin
    a_found = 1'b0;
    b_found = 1'b0;
    m_found = 1'b0;
    a_age   = '0;
    b_age   = '0;
    m_age   = '0;
    for (int j = 0; j < IQ_DEPTH; j++) begin
      if (alu_rot[j]) begin
        if (!a_found) begin
          a_found = 1'b1;
          a_age   = POS_W'(j);
        end else if (!b_found) begin
          b_found = 1'b1;
          b_age   = POS_W'(j);
        end
      end
      if (mem_rot[j] && !m_found) begin
        m_found = 1'b1;
        m_age   = POS_W'(j);
      end
    end
  end

  assign a_pos    = bus.head + a_age;
  assign b_pos    = bus.head + b_age;
  assign m_pos    = bus.head + m_age;
  assign mem_fire = m_found & bus.nodep[m_pos] & bus.mem_ready & ~bus.flush;

  always_comb begin
    s0_fire = 1'b0;
    s1_fire = 1'b0;
    s0_pos  = a_pos;
    s1_pos  = a_pos;
    if (!bus.flush) begin
      case (bus.alu_ready)
        2'b11: begin
          s0_fire = a_found;
          s1_fire = b_found;
          s1_pos  = b_pos;
        end
        2'b10:   s1_fire = a_found;
        2'b01:   s0_fire = a_found;
        default: ;
      endcase
    end
  end

  always_comb begin
    set_vec = '0;
    if (s0_fire)  set_vec[s0_pos] = 1'b1;
    if (s1_fire)  set_vec[s1_pos] = 1'b1;
    if (mem_fire) set_vec[m_pos]  = 1'b1;
  end

  assign clr_vec     = ~bus.validbit | bus.replay | {IQ_DEPTH{bus.flush}};
  assign issued_next = (issued_reg | set_vec) & ~clr_vec;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      issued_reg     <= '0;
      alu_valid_reg  <= '0;
      alu_iqpos0_reg <= '0;
      alu_iqpos1_reg <= '0;
      mem_valid_reg  <= 1'b0;
      mem_iqpos_reg  <= '0;
    end else begin
      issued_reg    <= issued_next;
      alu_valid_reg <= {s1_fire, s0_fire};
      mem_valid_reg <= mem_fire;
      if (bus.flush) begin
        alu_iqpos0_reg <= '0;
        alu_iqpos1_reg <= '0;
        mem_iqpos_reg  <= '0;
      end else begin
        // Positions hold their last value while the slot is idle.
        if (s0_fire)  alu_iqpos0_reg <= s0_pos;
        if (s1_fire)  alu_iqpos1_reg <= s1_pos;
        if (mem_fire) mem_iqpos_reg  <= m_pos;
      end
    end
  end

  assign bus.issued     = issued_reg;
  assign bus.alu_valid  = alu_valid_reg;
  assign bus.alu_iqpos0 = alu_iqpos0_reg;
  assign bus.alu_iqpos1 = alu_iqpos1_reg;
  assign bus.mem_valid  = mem_valid_reg;
  assign bus.mem_iqpos  = mem_iqpos_reg;

endmodule

// File: tb/tb_iq_issue_sched.sv
// Directed test-plan sequences plus randomized traffic, checked against an
// age-ordered behavioural model of the scheduler.
module tb_iq_issue_sched;
  localparam int D = 8;

  logic clk;
  logic nrst;
  int   checks;
  int   failures;

  iq_issue_sched_if #(.IQ_DEPTH(D), .POS_W(3)) bus ();

  iq_issue_sched #(.IQ_DEPTH(D), .POS_W(3)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: what the outputs should show after the last edge.
  logic [7:0] m_issued;
  logic [1:0] m_av;
  int         m_p0, m_p1, m_mp;
  logic       m_mv;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_issued = '0;
    m_av     = '0;
    m_p0     = 0;
    m_p1     = 0;
    m_mp     = 0;
    m_mv     = 1'b0;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".alu_valid"}, int'(bus.alu_valid), int'(m_av));
    check({tag, ".pos0"},      int'(bus.alu_iqpos0), m_p0);
    check({tag, ".pos1"},      int'(bus.alu_iqpos1), m_p1);
    check({tag, ".mem_valid"}, int'(bus.mem_valid), int'(m_mv));
    check({tag, ".mem_pos"},   int'(bus.mem_iqpos), m_mp);
    check({tag, ".issued"},    int'(bus.issued), int'(m_issued));
  endtask

  task automatic drive(input logic [7:0] v, input logic [7:0] m, input logic [7:0] n,
                       input logic [2:0] h, input logic [1:0] ar, input logic mr,
                       input logic [7:0] rp, input logic fl);
    bus.validbit  = v;
    bus.is_mem    = m;
    bus.nodep     = n;
    bus.head      = h;
    bus.alu_ready = ar;
    bus.mem_ready = mr;
    bus.replay    = rp;
    bus.flush     = fl;
  endtask

  // Predict the next edge from current inputs, clock it, then compare.
  task automatic step(input string tag);
    logic [7:0] n_iss;
    logic [1:0] n_av;
    logic       n_mv;
    int         n_p0, n_p1, n_mp, m, idx;
    int         alu_q[$];
    n_av  = '0;
    n_mv  = 1'b0;
    n_p0  = m_p0;
    n_p1  = m_p1;
    n_mp  = m_mp;
    n_iss = m_issued;
    if (bus.flush) begin
      n_iss = '0;
      n_p0  = 0;
      n_p1  = 0;
      n_mp  = 0;
    end else begin
      m = -1;
      for (int a = 0; a < D; a++) begin
        idx = (int'(bus.head) + a) % D;
        if (bus.validbit[idx] && !m_issued[idx]) begin
          if (!bus.is_mem[idx] && bus.nodep[idx]) alu_q.push_back(idx);
          if (bus.is_mem[idx] && m < 0) m = idx;
        end
      end
      if (bus.alu_ready == 2'b11) begin
        if (alu_q.size() > 0) begin n_av[0] = 1'b1; n_p0 = alu_q[0]; end
        if (alu_q.size() > 1) begin n_av[1] = 1'b1; n_p1 = alu_q[1]; end
      end else if (bus.alu_ready == 2'b10 && alu_q.size() > 0) begin
        n_av[1] = 1'b1; n_p1 = alu_q[0];
      end else if (bus.alu_ready == 2'b01 && alu_q.size() > 0) begin
        n_av[0] = 1'b1; n_p0 = alu_q[0];
      end
      if (m >= 0 && bus.nodep[m] && bus.mem_ready) begin
        n_mv = 1'b1; n_mp = m;
      end
      if (n_av[0]) n_iss[n_p0] = 1'b1;
      if (n_av[1]) n_iss[n_p1] = 1'b1;
      if (n_mv)    n_iss[n_mp] = 1'b1;
      for (int i = 0; i < D; i++)
        if (!bus.validbit[i] || bus.replay[i]) n_iss[i] = 1'b0;
    end
    @(posedge clk);
    #1;
    m_issued = n_iss;
    m_av     = n_av;
    m_mv     = n_mv;
    m_p0     = n_p0;
    m_p1     = n_p1;
    m_mp     = n_mp;
    check_model(tag);
  endtask

  task automatic async_reset(input string tag);
    #2;
    nrst = 1'b0;
    #1;
    model_reset();
    check({tag, ".alu_valid"}, int'(bus.alu_valid), 0);
    check({tag, ".mem_valid"}, int'(bus.mem_valid), 0);
    check({tag, ".issued"},    int'(bus.issued), 0);
    check_model(tag);
    @(negedge clk);
    nrst = 1'b1;
  endtask

  initial begin
    logic [7:0] mem_map;
    logic [2:0] hd;
    checks   = 0;
    failures = 0;
    nrst     = 1'b0;
    model_reset();
    drive(8'h00, 8'h00, 8'h00, 3'd0, 2'b00, 1'b0, 8'h00, 1'b0);
    #12;
    check_model("reset");
    @(negedge clk);
    nrst = 1'b1;

    // Age order with wrap.
    drive(8'b1100_0010, 8'h00, 8'hFF, 3'd6, 2'b11, 1'b0, 8'h00, 1'b0);
    step("wrap1");
    check("wrap1.s0", int'(bus.alu_iqpos0), 6);
    check("wrap1.s1", int'(bus.alu_iqpos1), 7);
    step("wrap2");
    check("wrap2.valid", int'(bus.alu_valid), 1);
    check("wrap2.s0", int'(bus.alu_iqpos0), 1);
    check("wrap2.issued", int'(bus.issued), 8'hC2);
    drive(8'h00, 8'h00, 8'h00, 3'd0, 2'b00, 1'b0, 8'h00, 1'b1);
    step("clr1");

    // Single ready slot.
    drive(8'b0000_1100, 8'h00, 8'hFF, 3'd0, 2'b10, 1'b0, 8'h00, 1'b0);
    step("single1");
    check("single1.valid", int'(bus.alu_valid), 2);
    check("single1.s1", int'(bus.alu_iqpos1), 2);
    bus.alu_ready = 2'b11;
    step("single2");
    check("single2.valid", int'(bus.alu_valid), 1);
    check("single2.s0", int'(bus.alu_iqpos0), 3);

    // Memory ordering.
    drive(8'b0001_0010, 8'b0001_0010, 8'b0001_0000, 3'd0, 2'b00, 1'b1, 8'h00, 1'b0);
    step("memord1");
    check("memord1.mv", int'(bus.mem_valid), 0);
    bus.nodep = 8'hFF;
    step("memord2");
    check("memord2.pos", int'(bus.mem_iqpos), 1);
    step("memord3");
    check("memord3.mv", int'(bus.mem_valid), 1);
    check("memord3.pos", int'(bus.mem_iqpos), 4);
    step("memord4");

    // Replay.
    drive(8'b0010_0000, 8'b0010_0000, 8'hFF, 3'd0, 2'b00, 1'b1, 8'h00, 1'b0);
    step("replay1");
    step("replay2");
    bus.replay = 8'b0010_0000;
    step("replay3");
    check("replay3.bit5", int'(bus.issued[5]), 0);
    bus.replay = 8'h00;
    step("replay4");
    check("replay4.mv", int'(bus.mem_valid), 1);
    check("replay4.pos", int'(bus.mem_iqpos), 5);

    // Flush and asynchronous reset mid-stream.
    drive(8'hFF, 8'h01, 8'hFF, 3'd0, 2'b11, 1'b1, 8'h00, 1'b0);
    step("stream1");
    bus.flush = 1'b1;
    step("flush");
    check("flush.issued", int'(bus.issued), 0);
    bus.flush = 1'b0;
    step("stream2");
    async_reset("areset");

    // Dealloc and immediate reallocation.
    drive(8'b0000_1000, 8'h00, 8'hFF, 3'd0, 2'b01, 1'b0, 8'h00, 1'b0);
    step("dealloc1");
    bus.validbit = 8'h00;
    step("dealloc2");
    check("dealloc2.bit3", int'(bus.issued[3]), 0);
    bus.validbit = 8'b0000_1000;
    step("dealloc3");
    check("dealloc3.valid", int'(bus.alu_valid), 1);
    check("dealloc3.s0", int'(bus.alu_iqpos0), 3);

    // Randomized traffic.
    mem_map = 8'($urandom);
    hd      = 3'($urandom);
    for (int c = 0; c < 400; c++) begin
      if (c % 16 == 0)  mem_map = 8'($urandom);
      if (c % 11 == 0)  hd = 3'($urandom);
      drive(8'($urandom | $urandom | $urandom), mem_map, 8'($urandom | $urandom), hd,
            2'($urandom), 1'($urandom_range(0, 3) != 0),
            ($urandom_range(0, 7) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00,
            $urandom_range(0, 39) == 0);
      step("rand");
      if (c == 200) async_reset("rand_areset");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end
endmodule
